multi_tap_btn_ctrl: RTL and testbench
=====================================

Name: multi_tap_btn_ctrl

Overview:
Parametrised multi-channel button front end that generalises the single-channel double-click monitor.
- Per channel: synchronises and debounces a raw push-button, then counts taps within an inter-tap gap window.
- Emits one classified event per gesture (tap count, optionally long-press).
- Toggles a per-channel LED on each exact double-tap.
- Sits between the board buttons/LEDs and the application logic, and carries its own ms-tick prescaler from the board clock.

Parameters:
N_CH, 3, number of independent button channels
CLK_DIV, 50000, clk cycles per 1 ms tick (50 MHz board clock)
DEBOUNCE_MS, 10, ticks of stable level required to accept a debounced level change
GAP_MS, 400, max released time (ticks) between taps of one gesture
LONG_MS, 1000, held time (ticks) classified as long press (optional feature only)
CNT_W, 3, tap-count width; count saturates at 2^CNT_W-1

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
btn  in  N_CH  raw buttons, active-high, asynchronous to clk
evt_valid  out  N_CH  one-cycle pulse per completed gesture, per channel
evt_taps  out  N_CH*CNT_W  tap count of the gesture; channel i at [i*CNT_W +: CNT_W]; valid while evt_valid[i]=1
evt_long  out  N_CH  gesture ended in a long press; qualified by evt_valid
led  out  N_CH  toggles on each event with taps==2 and evt_long==0
tick  out  1  1 ms strobe, one clk cycle wide

Behaviour:
- Reset: all outputs 0; prescaler, sync FFs, debounce counters, timers and tap counts 0; FSMs in IDLE; debounced level 0. Reset is asynchronous. Asserting it mid-gesture discards the gesture: no event, LED keeps its reset value 0.
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick=1 in the cycle the count equals CLK_DIV-1.
- Synchroniser: 2-FF per channel. The debouncer sees btn with 2-cycle latency.
- Debouncer: per-channel counter.
  - Clears whenever the sync level equals the debounced level.
  - Otherwise increments on tick.
  - When it reaches DEBOUNCE_MS, the debounced level takes the sync level and the counter clears.
- Per-channel FSM, clocked on clk; timers advance only on tick. Timer width is $clog2(max(GAP_MS,LONG_MS)+1).
  - IDLE: debounced rise -> PRESSED, taps=1, timer=0.
  - PRESSED: debounced fall -> RELEASED, timer=0.
  - RELEASED, debounced rise with timer<GAP_MS -> PRESSED; taps=taps+1, saturating at 2^CNT_W-1 (no wrap); timer=0.
  - RELEASED, timer reaches GAP_MS on a tick -> evt_valid=1 next clk cycle with evt_taps=taps; then IDLE and taps=0.
  - A rise and gap expiry in the same cycle: the rise wins (tap counted, no event).
- LED: led[i] toggles in the cycle evt_valid[i]=1 when evt_taps==2 and evt_long==0. Taps 1 and ≥3 leave it unchanged.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- Without the optional feature, PRESSED has no timeout; a held button produces no event until released and the gap expires.

Optional Feature:
Macro: LONG_PRESS_EN.
- Defined: in PRESSED, the timer counts held ticks. On reaching LONG_MS:
  - evt_valid=1 and evt_long=1 next cycle, with evt_taps=current taps.
  - FSM enters HOLD. HOLD waits for the debounced fall, then goes to IDLE with no further event.
- Not defined: HOLD state and long timer are absent; evt_long is tied to 0.

Test Plan:
All scenarios use simulation parameters CLK_DIV=10, DEBOUNCE_MS=2, GAP_MS=20, LONG_MS=50, CNT_W=3, N_CH=3.
- Bounce rejection: btn[0] toggles every 5 clk for 200 clk, then stays 0 -> no evt_valid; led=0; tick period is exactly 10 clk.
- Single tap: btn[0] high 100 clk, then low -> one evt_valid[0] about 200 clk after the debounced fall; evt_taps ch0=1; led[0] stays 0.
- Double tap: two 100-clk presses separated by 100 clk low -> one event with taps=2; led[0] 0->1. Repeating the pattern -> led[0] 1->0.
- Saturation and independence: 9 quick taps on btn[1] while btn[2] double-taps -> ch1 taps=7 and ch2 taps=2. Only led[2] toggles; events are independent.
- Reset mid-gesture: rstn low for 3 clk between the two presses of a double tap -> no event; all outputs 0 after reset. A subsequent double tap -> taps=2.
- LONG_PRESS_EN defined: btn[0] held 1000 clk -> evt_valid with evt_long=1 and taps=1 about 500 clk after the debounced rise; release -> no second event; led unchanged. Without the macro, the same stimulus gives evt_long=0 and taps=1 after release plus gap.

Source files
------------

// File: rtl/multi_tap_btn_ctrl.sv
// Multi-channel button front end: sync, debounce, tap counting and gesture events.
// Optional long-press classification is enabled by defining LONG_PRESS_EN.
module multi_tap_btn_ctrl #(
    parameter int N_CH        = 3,
    parameter int CLK_DIV     = 50000,
    parameter int DEBOUNCE_MS = 10,
    parameter int GAP_MS      = 400,
    parameter int LONG_MS     = 1000,
    parameter int CNT_W       = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_CH-1:0]         btn,
    output logic [N_CH-1:0]         evt_valid,
    output logic [N_CH*CNT_W-1:0]   evt_taps,
    output logic [N_CH-1:0]         evt_long,
    output logic [N_CH-1:0]         led,
    output logic                    tick
);

    localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW   = $clog2(DEBOUNCE_MS + 1);
    localparam int TMAX = (GAP_MS > LONG_MS) ? GAP_MS : LONG_MS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0]    DB_LAST    = DW'(DEBOUNCE_MS - 1);
    localparam logic [TW-1:0]    GAP_LAST   = TW'(GAP_MS - 1);
    localparam logic [CNT_W-1:0] TAPS_MAX   = '1;
`ifdef LONG_PRESS_EN
    localparam logic [TW-1:0]    LONG_LAST  = TW'(LONG_MS - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_RELEASED
`ifdef LONG_PRESS_EN
        , ST_HOLD
`endif
    } state_e;

    logic [PW-1:0]    presc_q, presc_d;
    logic [N_CH-1:0]  sync1_q, sync2_q;
    logic [N_CH-1:0]  dbLvl_q, dbRise_q, dbFall_q;
    logic [DW-1:0]    dbCnt_q [N_CH];

    state_e           state_q  [N_CH];
    logic [CNT_W-1:0] taps_q   [N_CH];
    logic [TW-1:0]    timer_q  [N_CH];
    logic [N_CH-1:0]  evtValid_q;
    logic [CNT_W-1:0] evtTaps_q [N_CH];
    logic [N_CH-1:0]  led_q;
`ifdef LONG_PRESS_EN
    logic [N_CH-1:0]  evtLong_q;
`endif

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // The debouncer emits one-cycle rise/fall pulses when the accepted level flips.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            dbLvl_q  <= '0;
            dbRise_q <= '0;
            dbFall_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                dbCnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            dbRise_q <= '0;
            dbFall_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (sync2_q[i] == dbLvl_q[i]) begin
                    dbCnt_q[i] <= '0;
                end else if (tick) begin
                    if (dbCnt_q[i] == DB_LAST) begin
                        dbCnt_q[i]  <= '0;
                        dbLvl_q[i]  <= sync2_q[i];
                        dbRise_q[i] <= sync2_q[i];
                        dbFall_q[i] <= ~sync2_q[i];
                    end else begin
                        dbCnt_q[i] <= dbCnt_q[i] + DW'(1);
                    end
                end
            end
        end
    end

    // A tap arriving in the same cycle as gap expiry wins because the rise is tested first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evtValid_q <= '0;
            led_q      <= '0;
`ifdef LONG_PRESS_EN
            evtLong_q  <= '0;
`endif
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]   <= ST_IDLE;
                taps_q[i]    <= '0;
                timer_q[i]   <= '0;
                evtTaps_q[i] <= '0;
            end
        end else begin
            evtValid_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (dbRise_q[i]) begin
                            state_q[i] <= ST_PRESSED;
                            taps_q[i]  <= CNT_W'(1);
                            timer_q[i] <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (dbFall_q[i]) begin
                            state_q[i] <= ST_RELEASED;
                            timer_q[i] <= '0;
                        end
`ifdef LONG_PRESS_EN
                        else if (tick) begin
                            if (timer_q[i] == LONG_LAST) begin
                                evtValid_q[i] <= 1'b1;
                                evtTaps_q[i]  <= taps_q[i];
                                evtLong_q[i]  <= 1'b1;
                                state_q[i]    <= ST_HOLD;
                                timer_q[i]    <= '0;
                            end else begin
                                timer_q[i] <= timer_q[i] + TW'(1);
                            end
                        end
`endif
                    end
                    ST_RELEASED: begin
                        if (dbRise_q[i]) begin
                            state_q[i] <= ST_PRESSED;
                            timer_q[i] <= '0;
                            if (taps_q[i] != TAPS_MAX) begin
                                taps_q[i] <= taps_q[i] + CNT_W'(1);
                            end
                        end else if (tick) begin
                            if (timer_q[i] == GAP_LAST) begin
                                evtValid_q[i] <= 1'b1;
                                evtTaps_q[i]  <= taps_q[i];
`ifdef LONG_PRESS_EN
                                evtLong_q[i]  <= 1'b0;
`endif
                                if (taps_q[i] == CNT_W'(2)) begin
                                    led_q[i] <= ~led_q[i];
                                end
                                state_q[i] <= ST_IDLE;
                                taps_q[i]  <= '0;
                                timer_q[i] <= '0;
                            end else begin
                                timer_q[i] <= timer_q[i] + TW'(1);
                            end
                        end
                    end
`ifdef LONG_PRESS_EN
                    ST_HOLD: begin
                        if (dbFall_q[i]) begin
                            state_q[i] <= ST_IDLE;
                            taps_q[i]  <= '0;
                            timer_q[i] <= '0;
                        end
                    end
`endif
                    default: begin
                        state_q[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign evt_valid = evtValid_q;
    assign led       = led_q;
`ifdef LONG_PRESS_EN
    assign evt_long  = evtLong_q;
`else
    assign evt_long  = '0;
`endif

    for (genvar g = 0; g < N_CH; g++) begin : gTaps
        assign evt_taps[g*CNT_W +: CNT_W] = evtTaps_q[g];
    end

endmodule

// File: tb/tb_multi_tap_btn_ctrl.sv
// Bench for multi_tap_btn_ctrl: expected gestures are queued as stimulus is driven
// and matched against each evt_valid pulse. Honors LONG_PRESS_EN when defined.
module tb_multi_tap_btn_ctrl;

    localparam int N_CH        = 3;
    localparam int CLK_DIV     = 10;
    localparam int DEBOUNCE_MS = 2;
    localparam int GAP_MS      = 20;
    localparam int LONG_MS     = 50;
    localparam int CNT_W       = 3;

    logic                  clk  = 1'b0;
    logic                  rstn = 1'b0;
    logic [N_CH-1:0]       btn  = '0;
    logic [N_CH-1:0]       evt_valid;
    logic [N_CH*CNT_W-1:0] evt_taps;
    logic [N_CH-1:0]       evt_long;
    logic [N_CH-1:0]       led;
    logic                  tick;

    typedef struct {
        int ch;
        int taps;
        int lng;
        int led;
    } exp_t;

    exp_t expQ[$];
    int   ledModel[N_CH];
    int   lastEvtCycle[N_CH];
    int   vecCount  = 0;
    int   missCount = 0;
    int   cycle     = 0;
    int   monIdx;
    exp_t monE;
    int   markCycle;
    logic [N_CH-1:0] ledExp;
    logic [N_CH-1:0] stim;

    multi_tap_btn_ctrl #(
        .N_CH(N_CH), .CLK_DIV(CLK_DIV), .DEBOUNCE_MS(DEBOUNCE_MS),
        .GAP_MS(GAP_MS), .LONG_MS(LONG_MS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn), .btn(btn), .evt_valid(evt_valid),
        .evt_taps(evt_taps), .evt_long(evt_long), .led(led), .tick(tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecCount++;
        assert (obs === expv) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic expectEvent(input int ch, input int taps, input int lng);
        exp_t e;
        if (taps == 2 && lng == 0) ledModel[ch] ^= 1;
        e.ch   = ch;
        e.taps = taps;
        e.lng  = lng;
        e.led  = ledModel[ch];
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] b, input int cycles);
        btn = b;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic doubleTap(input logic [N_CH-1:0] mask);
        applyStimulus(mask, 100);
        applyStimulus('0, 100);
        applyStimulus(mask, 100);
        applyStimulus('0, 1);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("scoreboard_drained", expQ.size(), 0);
    endtask

    task automatic measureTick();
        int n;
        n = 0;
        @(negedge clk);
        while (!tick && n < 2*CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 2*CLK_DIV);
        checkOutput("tick_period", n, CLK_DIV);
        @(posedge clk);
        #1;
    endtask

    task automatic checkLeds(input string tag);
        for (int i = 0; i < N_CH; i++) ledExp[i] = ledModel[i][0];
        checkOutput(tag, led, ledExp);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            for (int i = 0; i < N_CH; i++) begin
                if (evt_valid[i]) begin
                    monIdx = -1;
                    for (int k = 0; k < expQ.size(); k++)
                        if (monIdx < 0 && expQ[k].ch == i) monIdx = k;
                    checkOutput($sformatf("evt_expected_ch%0d", i), monIdx >= 0, 1);
                    if (monIdx >= 0) begin
                        monE = expQ[monIdx];
                        expQ.delete(monIdx);
                        checkOutput($sformatf("evt_taps_ch%0d", i), evt_taps[i*CNT_W +: CNT_W], monE.taps);
                        checkOutput($sformatf("evt_long_ch%0d", i), evt_long[i], monE.lng);
                        checkOutput($sformatf("led_at_evt_ch%0d", i), led[i], monE.led);
                    end
                    lastEvtCycle[i] = cycle;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete, missCount %0d expected 0", missCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            ledModel[i]     = 0;
            lastEvtCycle[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_evt_valid", evt_valid, 0);
        checkOutput("reset_evt_taps", evt_taps, 0);
        checkOutput("reset_evt_long", evt_long, 0);
        checkOutput("reset_led", led, 0);
        checkOutput("reset_tick", tick, 0);
        rstn = 1'b1;

        // Bounce shorter than one tick must never be accepted
        for (int k = 0; k < 40; k++) begin
            stim = (k % 2 == 0) ? 3'b001 : 3'b000;
            applyStimulus(stim, 5);
        end
        applyStimulus('0, 300);
        checkOutput("bounce_led", led, 0);
        measureTick();
        measureTick();
        measureTick();

        expectEvent(0, 1, 0);
        applyStimulus(3'b001, 100);
        markCycle = cycle;
        applyStimulus('0, 1);
        waitDrain(400);
        checkOutput("single_latency_ok",
                    (lastEvtCycle[0] - markCycle >= 195) && (lastEvtCycle[0] - markCycle <= 240), 1);
        checkLeds("single_led");
        applyStimulus('0, 50);

        expectEvent(0, 2, 0);
        doubleTap(3'b001);
        waitDrain(400);
        checkLeds("double1_led");
        expectEvent(0, 2, 0);
        doubleTap(3'b001);
        waitDrain(400);
        checkLeds("double2_led");

        // Ch1 taps nine times while ch2 double-taps in parallel
        expectEvent(2, 2, 0);
        expectEvent(1, 7, 0);
        for (int t = 0; t < 800; t++) begin
            stim    = '0;
            stim[1] = (t < 720) && ((t % 80) < 40);
            stim[2] = (t < 100) || (t >= 200 && t < 300);
            applyStimulus(stim, 1);
        end
        waitDrain(600);
        checkLeds("sat_led");

        applyStimulus(3'b001, 100);
        applyStimulus('0, 100);
        rstn = 1'b0;
        for (int i = 0; i < N_CH; i++) ledModel[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midreset_evt_valid", evt_valid, 0);
        checkOutput("midreset_evt_taps", evt_taps, 0);
        checkOutput("midreset_evt_long", evt_long, 0);
        checkOutput("midreset_led", led, 0);
        checkOutput("midreset_tick", tick, 0);
        rstn = 1'b1;
        applyStimulus('0, 300);

        expectEvent(0, 2, 0);
        expectEvent(1, 2, 0);
        doubleTap(3'b011);
        waitDrain(400);
        checkOutput("simul_same_cycle", lastEvtCycle[0] == lastEvtCycle[1], 1);
        checkLeds("simul_led");

`ifdef LONG_PRESS_EN
        expectEvent(0, 1, 1);
        markCycle = cycle;
        applyStimulus(3'b001, 1000);
        checkOutput("long_latency_ok",
                    (lastEvtCycle[0] - markCycle >= 500) && (lastEvtCycle[0] - markCycle <= 540), 1);
        applyStimulus('0, 400);
        waitDrain(1);
`else
        expectEvent(0, 1, 0);
        applyStimulus(3'b001, 1000);
        markCycle = cycle;
        applyStimulus('0, 1);
        waitDrain(400);
        checkOutput("held_latency_ok",
                    (lastEvtCycle[0] - markCycle >= 195) && (lastEvtCycle[0] - markCycle <= 240), 1);
`endif
        applyStimulus('0, 300);
        checkLeds("long_led");
        waitDrain(1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
